// File: rtl/parity_link_pkg.sv
// Shared definitions for the XOR-parity serial link (receiver and transmitter).
package parity_link_pkg;

  localparam int DEF_DATA_W = 8;

  // Parity sense selectors, shared with the matching transmitter.
  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  // Frame-walker state encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } rx_state_t;

  // Bit counter width: must hold 0..n without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/parity_frame_rx_if.sv
// Bundle of line-side strobe/data inputs and word-side outputs of the parity receiver.
interface parity_frame_rx_if
  import parity_link_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              bit_en;
  logic              rx_in;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  // Line sampler / bit-timing side drives the strobe and line, observes results.
  modport master (
    output bit_en, rx_in,
    input  data_out, valid, parity_err, frame_err, busy
  );

  // Receiver side.
  modport slave (
    input  bit_en, rx_in,
    output data_out, valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/parity_xor_acc.sv
// Running 1-bit XOR accumulator with clear and enable; also used by the transmitter.
module parity_xor_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic bit_i,
  output logic acc_o
);

  logic acc_q, acc_d;

  // Clear takes priority over accumulation.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = 1'b0;
    end else if (en_i) begin
      acc_d = acc_q ^ bit_i;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/parity_frame_rx.sv
// Parity-checking serial frame receiver: start, DATA_W data bits LSB first,
// parity, stop. Every transition is gated by the external bit strobe.
module parity_frame_rx
  import parity_link_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter bit ODD    = PAR_EVEN
) (
  input logic              clk,
  input logic              rst,
  parity_frame_rx_if.slave rx_if
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d, shift_in;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;
  logic              acc_clr, acc_en, acc;

  parity_xor_acc u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .bit_i (rx_if.rx_in),
    .acc_o (acc)
  );

  // New bit enters at the MSB so the first data bit ends up in bit 0.
  generate
    if (DATA_W == 1) begin : g_shift1
      assign shift_in = rx_if.rx_in;
    end else begin : g_shiftn
      assign shift_in = {rx_if.rx_in, shift_q[DATA_W-1:1]};
    end
  endgenerate

  // Next-state and output decode; nothing moves unless bit_en is high.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    data_out_d   = data_out_q;
    valid_d      = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    busy_d       = busy_q;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
    if (rx_if.bit_en) begin
      case (state_q)
        IDLE: begin
          if (!rx_if.rx_in) begin
            state_d = DATA;
            cnt_d   = '0;
            acc_clr = 1'b1;
            busy_d  = 1'b1;
          end
        end
        DATA: begin
          shift_d = shift_in;
          acc_en  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          perr_d  = acc ^ rx_if.rx_in ^ ODD;
          state_d = STOP;
        end
        STOP: begin
          // Emit straight from the stop-bit strobe so valid follows one clk later.
          data_out_d   = shift_q;
          parity_err_d = perr_q;
          frame_err_d  = ~rx_if.rx_in;
          valid_d      = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter, shift register, parity flag and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      data_out_q   <= data_out_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_if.data_out   = data_out_q;
  assign rx_if.valid      = valid_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.busy       = busy_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: an even-parity and an odd-parity receiver share one line.
module tb_parity_frame_rx;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic bit_en;
  logic rx_in;

  always #5 clk = ~clk;

  parity_frame_rx_if #(.DATA_W(W)) if_e ();
  parity_frame_rx_if #(.DATA_W(W)) if_o ();

  assign if_e.bit_en = bit_en;
  assign if_e.rx_in  = rx_in;
  assign if_o.bit_en = bit_en;
  assign if_o.rx_in  = rx_in;

  parity_frame_rx #(.DATA_W(W), .ODD(1'b0)) dut_e (.clk(clk), .rst(rst), .rx_if(if_e));
  parity_frame_rx #(.DATA_W(W), .ODD(1'b1)) dut_o (.clk(clk), .rst(rst), .rx_if(if_o));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    logic         perr;
    logic         ferr;
    int           cyc;
  } rec_t;

  typedef struct {
    logic [W-1:0] data;
    logic         pbit;
    logic         stop;
    int           gap;
    logic [W-1:0] exp_data;
    logic         exp_pe;
    logic         exp_po;
    logic         exp_fe;
  } vec_t;

  rec_t got_e[$], got_o[$], exp_e[$], exp_o[$];

  // Capture every valid pulse of each receiver with its cycle number.
  always @(negedge clk) begin
    rec_t r;
    if (if_e.valid) begin
      r.data = if_e.data_out; r.perr = if_e.parity_err; r.ferr = if_e.frame_err; r.cyc = cyc;
      got_e.push_back(r);
    end
    if (if_o.valid) begin
      r.data = if_o.data_out; r.perr = if_o.parity_err; r.ferr = if_o.frame_err; r.cyc = cyc;
      got_o.push_back(r);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic b, input int gap);
    bit_en = 1'b1;
    rx_in  = b;
    @(posedge clk); #1;
    bit_en = 1'b0;
    repeat (gap) begin
      rx_in = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic p, input logic s,
                            input int gap, output int stop_cyc);
    strobe(1'b0, gap);
    check("busy_in_frame_e", if_e.busy, 1);
    check("busy_in_frame_o", if_o.busy, 1);
    for (int i = 0; i < W; i++) strobe(d[i], gap);
    strobe(p, gap);
    stop_cyc = cyc;
    strobe(s, gap);
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic pe, input logic po,
                          input logic fe, input int stop_cyc);
    rec_t r;
    r.data = d; r.ferr = fe; r.cyc = stop_cyc + 1;
    r.perr = pe; exp_e.push_back(r);
    r.perr = po; exp_o.push_back(r);
  endtask

  // Behavioural model: count all ones in data+parity and compare with the parity sense.
  task automatic model_frame(input logic [W-1:0] d, input logic p, input logic s, input int stop_cyc);
    int ones;
    ones = $countones(d) + int'(p);
    push_exp(d, (ones % 2) != 0, (ones % 2) == 0, !s, stop_cyc);
  endtask

  task automatic cmp_rec(input string nm, input rec_t g, input rec_t e);
    check({nm, "_data"}, g.data, e.data);
    check({nm, "_parity_err"}, g.perr, e.perr);
    check({nm, "_frame_err"}, g.ferr, e.ferr);
    check({nm, "_valid_cycle"}, g.cyc, e.cyc);
  endtask

  task automatic compare_all(input string tag);
    rec_t e;
    while (exp_e.size() > 0) begin
      e = exp_e.pop_front();
      if (got_e.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL %s_missing_valid_e: got none, expected data 0x%0h", tag, e.data);
      end else cmp_rec({tag, "_e"}, got_e.pop_front(), e);
    end
    while (exp_o.size() > 0) begin
      e = exp_o.pop_front();
      if (got_o.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL %s_missing_valid_o: got none, expected data 0x%0h", tag, e.data);
      end else cmp_rec({tag, "_o"}, got_o.pop_front(), e);
    end
    check({tag, "_extra_valid_e"}, got_e.size(), 0);
    check({tag, "_extra_valid_o"}, got_o.size(), 0);
    got_e.delete();
    got_o.delete();
  endtask

  vec_t tbl[4];

  initial begin
    int sc, sc2;
    logic [W-1:0] d;
    logic p, s;
    int g;

    tbl[0] = '{8'hA5, 1'b0, 1'b1, 3, 8'hA5, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'hA5, 1'b1, 1'b1, 3, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, 3, 8'h3C, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{8'h01, 1'b1, 1'b1, 3, 8'h01, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; bit_en = 1'b0; rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    check("rst_data_e", if_e.data_out, 0);
    check("rst_valid_e", if_e.valid, 0);
    check("rst_perr_e", if_e.parity_err, 0);
    check("rst_ferr_e", if_e.frame_err, 0);
    check("rst_busy_e", if_e.busy, 0);
    check("rst_busy_o", if_o.busy, 0);

    // Table-driven frames, strobe every 4 clks
    for (int i = 0; i < 4; i++) begin
      send_frame(tbl[i].data, tbl[i].pbit, tbl[i].stop, tbl[i].gap, sc);
      push_exp(tbl[i].exp_data, tbl[i].exp_pe, tbl[i].exp_po, tbl[i].exp_fe, sc);
      rx_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("tbl%0d_busy_after_e", i), if_e.busy, 0);
      check($sformatf("tbl%0d_valid_low_e", i), if_e.valid, 0);
      compare_all($sformatf("tbl%0d", i));
    end

    // Reset after the 4th data bit of 0xFF
    strobe(1'b0, 1);
    for (int i = 0; i < 4; i++) strobe(1'b1, 1);
    rst = 1'b1; rx_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy_e", if_e.busy, 0);
    check("midrst_valid_e", if_e.valid, 0);
    check("midrst_data_e", if_e.data_out, 0);
    check("midrst_perr_o", if_o.parity_err, 0);
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_valid_e", got_e.size(), 0);
    check("midrst_no_valid_o", got_o.size(), 0);
    send_frame(8'h12, 1'b0, 1'b1, 1, sc);
    push_exp(8'h12, 1'b0, 1'b1, 1'b0, sc);
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compare_all("after_rst");

    // Back-to-back frames with bit_en every cycle
    send_frame(8'h55, 1'b0, 1'b1, 0, sc);
    send_frame(8'hAA, 1'b0, 1'b1, 0, sc2);
    push_exp(8'h55, 1'b0, 1'b1, 1'b0, sc);
    push_exp(8'hAA, 1'b0, 1'b1, 1'b0, sc2);
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (got_e.size() >= 2) check("b2b_spacing_e", got_e[1].cyc - got_e[0].cyc, 11);
    else begin
      n_checks++; n_fail++;
      $display("FAIL b2b_spacing_e: got %0d pulses, expected 2", got_e.size());
    end
    compare_all("b2b");

    // Line low without strobes in IDLE must be ignored
    rx_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("glitch_busy_%0d", i), if_e.busy, 0);
    end
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("glitch_busy_end_o", if_o.busy, 0);
    check("glitch_no_valid_e", got_e.size(), 0);
    check("glitch_no_valid_o", got_o.size(), 0);

    // Random frames against the model
    for (int i = 0; i < 40; i++) begin
      d = W'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 3) != 0);
      g = $urandom_range(0, 3);
      send_frame(d, p, s, g, sc);
      model_frame(d, p, s, sc);
    end
    rx_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    compare_all("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
